// File: rtl/bcd_to_bin_seq.sv
// Iterative 4-digit BCD-to-binary converter (reverse double-dabble), one shift per clock.
// Optional invalid-digit flagging is enabled by defining BCD2BIN_ERR_EN.
module bcd_to_bin_seq #(
    parameter int bitwidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          thousands,
    input  logic [3:0]          hundreds,
    input  logic [3:0]          tens,
    input  logic [3:0]          ones,
    output logic [bitwidth-1:0] binary,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [15:0]         bcd_q, bcd_d;
    // 16 bits wide so that all 16 shifted-out bits land; only [13:0] is significant.
    logic [15:0]         res_q, res_d;
    logic [bitwidth-1:0] bin_q, bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         bcd_sh, res_sh;
`ifdef BCD2BIN_ERR_EN
    logic                err_q, err_d;
    logic                inv_q, inv_d;
`endif

    // Per-nibble correction after a right shift; no carry crosses nibble boundaries.
    function automatic logic [15:0] dabble_fix(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i+3]) begin
                r[4*i +: 4] = r[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    // NOTE: every always_comb target gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        res_d   = res_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD2BIN_ERR_EN
        err_d   = 1'b0;
        inv_d   = inv_q;
`endif
        bcd_sh  = {1'b0, bcd_q[15:1]};
        res_sh  = {bcd_q[0], res_q[15:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = {thousands, hundreds, tens, ones};
                    res_d   = '0;
                    count_d = 5'd16;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef BCD2BIN_ERR_EN
                    inv_d   = (thousands > 4'd9) || (hundreds > 4'd9) ||
                              (tens > 4'd9) || (ones > 4'd9);
`endif
                end
            end
            SHIFT: begin
                bcd_d   = dabble_fix(bcd_sh);
                res_d   = res_sh;
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    bin_d       = '0;
                    bin_d[13:0] = res_sh[13:0];
`ifdef BCD2BIN_ERR_EN
                    err_d       = inv_q;
                    if (inv_q) begin
                        bin_d = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            bcd_q   <= '0;
            res_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD2BIN_ERR_EN
            err_q   <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            res_q   <= res_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD2BIN_ERR_EN
            err_q   <= err_d;
            inv_q   <= inv_d;
`endif
        end
    end

    assign binary = bin_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef BCD2BIN_ERR_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq; expected values are hand-computed.
// Define BCD2BIN_ERR_EN for both bench and RTL to exercise the invalid-digit flag.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic [15:0] binary;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    bcd_to_bin_seq #(.bitwidth(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .binary    (binary),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge. Raises start, waits (bounded) for done, and leaves the bench
    // #1 after the done edge so a caller may start the next conversion in the done cycle.
    task automatic convert(input string tag,
                           input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input bit chk_bin, input logic [15:0] exp_bin,
                           input logic exp_err, input int glitch_cycle);
        int          n;
        int          busy_bad;
        int          hold_bad;
        logic [15:0] prev;
        n        = 0;
        busy_bad = 0;
        hold_bad = 0;
        prev     = binary;
        thousands = d3; hundreds = d2; tens = d1; ones = d0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
        check({tag, " done@accept"}, {31'd0, done}, 32'd0);
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (busy !== 1'b1) busy_bad++;
            if (binary !== prev) hold_bad++;
            if (n == glitch_cycle) begin
                start = 1'b1;
                thousands = 4'd1; hundreds = 4'd1; tens = 4'd1; ones = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, n, 32'd16);
        check({tag, " busy held"}, busy_bad, 32'd0);
        check({tag, " binary held"}, hold_bad, 32'd0);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        if (chk_bin) check({tag, " binary"}, {16'd0, binary}, {16'd0, exp_bin});
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0;
        thousands = '0; hundreds = '0; tens = '0; ones = '0;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst binary", {16'd0, binary}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        check("idle busy", {31'd0, busy}, 32'd0);

        // 2. 1234 -> 0x04D2
        convert("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 16'h04D2, 1'b0, 0);

        // 3. 9999 then 0000 back-to-back (start raised in the done cycle)
        convert("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 16'h270F, 1'b0, 0);
        convert("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0, 0);
        @(posedge clk); #1;
        check("c0000 done width", {31'd0, done}, 32'd0);
        check("c0000 idle busy", {31'd0, busy}, 32'd0);

        // 4. 5007 with an ignored start pulse at cycle 5
        convert("c5007", 4'd5, 4'd0, 4'd0, 4'd7, 1'b1, 16'h138F, 1'b0, 5);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("c5007 no queued conv", seen, 32'd0);
        check("c5007 binary kept", {16'd0, binary}, 32'h138F);

        // 5. reset during conversion of 4321
        thousands = 4'd4; hundreds = 4'd3; tens = 4'd2; ones = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort busy@accept", {31'd0, busy}, 32'd1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort binary", {16'd0, binary}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort no done", seen, 32'd0);
        convert("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 16'h002A, 1'b0, 0);

        // 6. invalid digit
`ifdef BCD2BIN_ERR_EN
        convert("c1A00", 4'd1, 4'hA, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 0);
`else
        convert("c1A00", 4'd1, 4'hA, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 0);
`endif
        @(posedge clk); #1;
        check("c1A00 err width", {31'd0, err}, 32'd0);
        check("c1A00 done width", {31'd0, done}, 32'd0);

        // Valid conversion after an invalid one clears the flag
        convert("c0815", 4'd0, 4'd8, 4'd1, 4'd5, 1'b1, 16'h032F, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
